uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Transmit-side serializer that drains the 16-entry UART transmit FIFO and drives the UART TX pin.
- Frame format: 8N1 by default; parity and stop-bit count set by parameters.
- Pops one byte per frame through the FIFO read port (read_en / read_data / empty).
- Reports busy and frame-complete status to the UART peripheral register block.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200); legal range >= 2.
- PARITY_EN, 0, 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  transmitter enable from the control register
- fifo_empty  input  1  FIFO empty flag
- fifo_data  input  8  FIFO head byte; first-word-fall-through, valid whenever fifo_empty=0
- fifo_read_en  output  1  pop strobe to the FIFO; combinational, one cycle per byte
- tx  output  1  serial line, registered, idles high
- busy  output  1  high from the first cycle of the start bit to the last cycle of the final stop bit
- tx_done  output  1  one-cycle pulse in the cycle after the final stop bit completes

Behaviour:
- Clock and reset: clk is the only clock. reset is asynchronous and active-high.
- Reset values: tx=1, busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0, shift register=0. fifo_read_en=0 while reset is asserted.
- States: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY_EN=0.
- Baud counter: runs 0..CLKS_PER_BIT-1 inside each bit, so every bit holds tx stable for exactly CLKS_PER_BIT cycles. Counter width is $clog2(CLKS_PER_BIT).
- Launch condition: launch = enable & ~fifo_empty & (state==IDLE | last cycle of the final stop bit).
- On launch:
  - fifo_read_en=1 combinationally in that cycle.
  - On the same edge: shift register <= fifo_data, parity <= ^fifo_data ^ PARITY_ODD, state <= START, tx <= 0.
  - The FIFO advances on that same edge, so each byte is popped exactly once.
- Latency: tx falls exactly 1 cycle after the fifo_read_en cycle.
- START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: send 8 bits LSB first; each bit is shifted out at the bit boundary. Bit index runs 0..7, then go to PARITY or STOP.
- PARITY: tx = latched parity bit, held for CLKS_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle:
  - if launch is true, chain directly to START with no idle gap;
  - otherwise go to IDLE.
  - In both cases tx_done pulses 1 cycle later.
- Back-to-back frames: period is exactly (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
- enable low:
  - in IDLE: no pop;
  - mid-frame: the current frame completes unchanged, then no further pop.
- FIFO empty at a launch point: remain in or return to IDLE with tx=1. No read_en is issued while empty, so the FIFO never underflows.
- Reset mid-frame: tx returns to 1 immediately (asynchronously). The in-flight byte is discarded and not re-popped, and no tx_done is generated.
- fifo_data changing while not in a launch cycle: ignored; only the latched shift register drives tx.

Test Plan:
- CLKS_PER_BIT=4, FIFO holds 0xA5 -> fifo_read_en high 1 cycle; tx over 40 cycles = 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 cycles; tx_done pulses at cycle 41; busy high for exactly 40 cycles.
- Two bytes 0x00, 0xFF queued back-to-back -> second start bit begins on the cycle after the first stop bit ends (80 cycles total); fifo_read_en pulses exactly twice; fifo_empty=1 afterwards and tx idles at 1.
- PARITY_EN=1, 0xA5 (four ones) -> parity bit 0 with PARITY_ODD=0 and 1 with PARITY_ODD=1; frame is 44 cycles. STOP_BITS=2 -> 48 cycles.
- enable=0 with FIFO non-empty -> no fifo_read_en and tx stays 1. Drop enable mid-frame -> that frame completes and the next byte remains in the FIFO.
- Assert reset during DATA bit 3 -> tx=1 in the same cycle, busy=0, no tx_done, FIFO count unchanged. After release, the next queued byte transmits correctly.
- FIFO empty throughout -> fifo_read_en never asserts, tx=1, busy=0.

Source files
------------

// File: rtl/uart_tx_serializer_if.sv
// FIFO read port between the UART transmit FIFO and the TX serializer.
// First-word-fall-through: data is valid whenever fifo_empty is low.
interface uart_tx_serializer_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read_en;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_read_en
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_read_en
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one byte per frame from the TX FIFO
// and shifts it out as start, 8 data LSB first, optional parity, stop.
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  uart_tx_serializer_if.master        fifo,
  output logic                        tx,
  output logic                        busy,
  output logic                        tx_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_MAX = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;

  logic bit_end;
  logic last_stop;
  logic launch;

  assign bit_end   = (cnt_q == CNT_MAX);
  assign last_stop = (state_q == STOP) && bit_end
                     && (bit_q == STOP_MAX);
  // Gate with reset so the FIFO is never popped while held in reset.
  assign launch    = enable && !fifo.fifo_empty && !reset
                     && ((state_q == IDLE) || last_stop);

  assign fifo.fifo_read_en = launch;
  assign tx      = tx_q;
  assign busy    = (state_q != IDLE);
  assign tx_done = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (PARITY_EN) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_MAX) begin
            state_d = IDLE;
            bit_d   = '0;
            tx_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new frame may start from IDLE or chain off the final stop cycle.
    if (launch) begin
      state_d = START;
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = fifo.fifo_data;
      par_d   = (^fifo.fifo_data) ^ PARITY_ODD;
      tx_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: FIFO model, frame decoder
// scoreboard and cycle-exact waveform comparisons.
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en0 = 1'b0;
  logic tx0, busy0, done0;
  logic tx1, busy1, done1;
  logic tx2, busy2, done2;

  logic       fe = 1'b1;
  logic [7:0] fd = 8'h00;
  logic       push_en = 1'b0;
  logic [7:0] push_byte = 8'h00;
  logic [7:0] fifo_m[$];
  logic [7:0] pop_tmp;
  int         pops = 0;
  int         underflow = 0;

  logic       pfe = 1'b1;
  logic       pfe_n;
  logic       p_push = 1'b0;
  logic [7:0] pfd = 8'hA5;

  logic re0_s = 1'b0;
  logic re1_s = 1'b0;
  logic re2_s = 1'b0;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [127:0] cap_tx, cap_busy, cap_done, cap_re;
  logic [127:0] cap1_tx, cap1_done, cap2_tx, cap2_done;
  logic [127:0] e_tx, e_busy, e_done, e_re;

  uart_tx_serializer_if if0 ();
  uart_tx_serializer_if if1 ();
  uart_tx_serializer_if if2 ();

  assign if0.fifo_empty = fe;
  assign if0.fifo_data  = fd;
  assign if1.fifo_empty = pfe;
  assign if1.fifo_data  = pfd;
  assign if2.fifo_empty = pfe;
  assign if2.fifo_data  = pfd;

  uart_tx_serializer #(
    .CLKS_PER_BIT(CPB)
  ) u0 (
    .clk(clk), .reset(reset), .enable(en0), .fifo(if0.master),
    .tx(tx0), .busy(busy0), .tx_done(done0)
  );

  uart_tx_serializer #(
    .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0),
    .STOP_BITS(1)
  ) u1 (
    .clk(clk), .reset(reset), .enable(1'b1), .fifo(if1.master),
    .tx(tx1), .busy(busy1), .tx_done(done1)
  );

  uart_tx_serializer #(
    .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1),
    .STOP_BITS(2)
  ) u2 (
    .clk(clk), .reset(reset), .enable(1'b1), .fifo(if2.master),
    .tx(tx2), .busy(busy2), .tx_done(done2)
  );

  always #5 clk = ~clk;

  // read_en sampled just before the rising edge it acts on
  always begin
    @(negedge clk);
    #4;
    re0_s = if0.fifo_read_en;
    re1_s = if1.fifo_read_en;
    re2_s = if2.fifo_read_en;
  end

  always @(posedge clk) begin
    if (re0_s) begin
      if (fifo_m.size() > 0) begin
        pop_tmp = fifo_m.pop_front();
        pops++;
      end else begin
        underflow++;
      end
    end
    if (push_en) fifo_m.push_back(push_byte);
    pfe_n = pfe;
    if (re1_s || re2_s) pfe_n = 1'b1;
    if (p_push) pfe_n = 1'b0;
    #1;
    fe  = (fifo_m.size() == 0);
    fd  = fe ? 8'h00 : fifo_m[0];
    pfe = pfe_n;
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame decoder: every full frame on tx0 is popped against exp_q.
  initial begin
    logic [9:0] fr;
    logic bad, aborted;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && tx0 === 1'b0) begin
        bad = 1'b0;
        aborted = 1'b0;
        fr = '0;
        for (int i = 0; i < 10 * CPB; i++) begin
          if (i != 0) begin
            @(negedge clk);
            #1;
          end
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (i % CPB == 0) fr[i / CPB] = tx0;
          else if (tx0 !== fr[i / CPB]) bad = 1'b1;
        end
        if (!aborted) begin
          chk("frame_shape", {bad, fr[0], fr[9]}, 3'b001);
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_frame", {120'h0, fr[8:1]}, 128'h0);
          end else begin
            e = exp_q.pop_front();
            chk("sb_byte", {120'h0, fr[8:1]}, {120'h0, e});
          end
        end
      end
    end
  end

  function automatic logic [15:0] frame_bits(input logic [7:0] b,
                                             input int pe,
                                             input int po);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = b;
    if (pe != 0) f[9] = (^b) ^ po[0];
    return f;
  endfunction

  task automatic build(input logic [7:0] b0, input logic [7:0] b1,
                       input int nfr, input int pe, input int po,
                       input int ns, input int n);
    int L, s;
    logic [15:0] fb;
    e_tx = '1;
    e_busy = '0;
    e_done = '0;
    e_re = '0;
    L = 1 + 8 + pe + ns;
    for (int f = 0; f < nfr; f++) begin
      fb = frame_bits((f == 0) ? b0 : b1, pe, po);
      s = 1 + f * L * CPB;
      e_re[s - 1] = 1'b1;
      for (int j = 0; j < L; j++)
        for (int c = 0; c < CPB; c++) begin
          e_tx[s + j * CPB + c] = fb[j];
          e_busy[s + j * CPB + c] = 1'b1;
        end
      e_done[s + L * CPB] = 1'b1;
    end
    for (int i = n + 1; i < 128; i++) begin
      e_tx[i] = 1'b0;
      e_busy[i] = 1'b0;
      e_done[i] = 1'b0;
      e_re[i] = 1'b0;
    end
  endtask

  task automatic capture(input int n);
    cap_tx = '0; cap_busy = '0; cap_done = '0; cap_re = '0;
    cap1_tx = '0; cap1_done = '0; cap2_tx = '0; cap2_done = '0;
    for (int i = 0; i <= n; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      cap_tx[i] = tx0;
      cap_busy[i] = busy0;
      cap_done[i] = done0;
      cap_re[i] = if0.fifo_read_en;
      cap1_tx[i] = tx1;
      cap1_done[i] = done1;
      cap2_tx[i] = tx2;
      cap2_done[i] = done2;
    end
  endtask

  task automatic push(input logic [7:0] b, input bit to_sb);
    @(negedge clk);
    push_en = 1'b1;
    push_byte = b;
    if (to_sb) exp_q.push_back(b);
    @(negedge clk);
    push_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    #1;
    while ((busy0 || !fe || done0) && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, k < 300, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic seen;

    // Reset values, and no pop while reset is held
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tx", tx0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    en0 = 1'b1;
    push(8'h3C, 1'b1);
    #1;
    chk("rst_no_read_en", if0.fifo_read_en, 0);
    @(negedge clk);
    reset = 1'b0;
    capture(42);
    build(8'h3C, 8'h00, 1, 0, 0, 1, 42);
    chk("3C_tx", cap_tx, e_tx);
    chk("3C_re", cap_re, e_re);
    wait_idle("3C_idle");

    // Single 0xA5 frame, exact waveform
    p0 = pops;
    push(8'hA5, 1'b1);
    capture(44);
    build(8'hA5, 8'h00, 1, 0, 0, 1, 44);
    chk("A5_tx", cap_tx, e_tx);
    chk("A5_busy", cap_busy, e_busy);
    chk("A5_done", cap_done, e_done);
    chk("A5_re", cap_re, e_re);
    chk("A5_pops", pops - p0, 1);
    wait_idle("A5_idle");

    // Parity variants: even/1 stop and odd/2 stop
    @(negedge clk);
    p_push = 1'b1;
    @(negedge clk);
    p_push = 1'b0;
    capture(52);
    build(8'hA5, 8'h00, 1, 1, 0, 1, 52);
    chk("par_even_tx", cap1_tx, e_tx);
    chk("par_even_done", cap1_done, e_done);
    build(8'hA5, 8'h00, 1, 1, 1, 2, 52);
    chk("par_odd_2stop_tx", cap2_tx, e_tx);
    chk("par_odd_2stop_done", cap2_done, e_done);

    // Back-to-back 0x00, 0xFF with no idle gap
    en0 = 1'b0;
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    p0 = pops;
    @(negedge clk);
    en0 = 1'b1;
    capture(84);
    build(8'h00, 8'hFF, 2, 0, 0, 1, 84);
    chk("b2b_tx", cap_tx, e_tx);
    chk("b2b_busy", cap_busy, e_busy);
    chk("b2b_done", cap_done, e_done);
    chk("b2b_re", cap_re, e_re);
    chk("b2b_pops", pops - p0, 2);
    chk("b2b_empty", fe, 1);

    // enable low while FIFO holds data
    en0 = 1'b0;
    push(8'h5A, 1'b0);
    capture(24);
    build(8'h00, 8'h00, 0, 0, 0, 1, 24);
    chk("dis_tx", cap_tx, e_tx);
    chk("dis_re", cap_re, e_re);
    chk("dis_fifo_cnt", fifo_m.size(), 1);
    exp_q.push_back(8'h5A);
    en0 = 1'b1;
    wait_idle("dis_resume_idle");

    // enable dropped mid-frame: frame completes, next byte stays
    en0 = 1'b0;
    push(8'h81, 1'b1);
    push(8'h7E, 1'b0);
    p0 = pops;
    @(negedge clk);
    en0 = 1'b1;
    repeat (10) @(negedge clk);
    en0 = 1'b0;
    capture(60);
    chk("mid_dis_re", cap_re, 0);
    chk("mid_dis_pops", pops - p0, 1);
    chk("mid_dis_fifo_cnt", fifo_m.size(), 1);
    chk("mid_dis_end", {cap_tx[60], cap_busy[60]}, 2'b10);
    exp_q.push_back(8'h7E);
    en0 = 1'b1;
    wait_idle("mid_dis_resume_idle");

    // Reset during data bit 3
    en0 = 1'b0;
    push(8'hC3, 1'b0);
    push(8'h96, 1'b1);
    @(negedge clk);
    en0 = 1'b1;
    repeat (18) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_tx", tx0, 1);
    chk("rst_mid_busy", busy0, 0);
    chk("rst_mid_fifo_cnt", fifo_m.size(), 1);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (done0 || if0.fifo_read_en || !tx0) seen = 1'b1;
    end
    chk("rst_mid_quiet", seen, 0);
    chk("rst_mid_fifo_hold", fifo_m.size(), 1);
    @(negedge clk);
    reset = 1'b0;
    capture(44);
    build(8'h96, 8'h00, 1, 0, 0, 1, 44);
    chk("rst_after_tx", cap_tx, e_tx);
    chk("rst_after_done", cap_done, e_done);
    chk("rst_after_re", cap_re, e_re);
    wait_idle("rst_after_idle");

    // FIFO empty throughout
    capture(30);
    build(8'h00, 8'h00, 0, 0, 0, 1, 30);
    chk("empty_tx", cap_tx, e_tx);
    chk("empty_busy", cap_busy, e_busy);
    chk("empty_re", cap_re, e_re);

    chk("no_underflow", underflow, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
